nibble_serial_adder: RTL and testbench

- Multi-cycle wide adder that adds two WIDTH-bit operands 4 bits at a time.
- Each cycle it drives the low nibbles of two operand shift registers and a registered carry into an internal 4-bit carry-lookahead slice (per-bit g=a&b, p=a^b, lookahead carries, s=p^c).
- It captures the slice's sum nibble and carry-out, then advances.
- It is the sequencing stage wrapped around the team's 4-bit CLA slice, giving wide additions without a wide carry chain.

---
 rtl/nibble_serial_adder.sv | 116 +++++++++++
 tb/tb_nibble_serial_adder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a 4-bit carry-lookahead slice,
// with the sum nibble shifted into the top of a result register.
module nibble_serial_adder #(
    parameter  int WIDTH   = 16,
    localparam int NIBBLES = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // 4-bit CLA slice on the low nibbles
    logic [3:0] g, p, s;
    logic [4:0] c;

    always_comb begin
        g    = opa_q[3:0] & opb_q[3:0];
        p    = opa_q[3:0] ^ opb_q[3:0];
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s    = p ^ c[3:0];
    end

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    opa_d   = a;
                    opb_d   = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = (res_q >> 4) | (WIDTH'(s) << (WIDTH - 4));
                carry_d = c[4];
                opa_d   = opa_q >> 4;
                opb_d   = opb_q >> 4;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(NIBBLES - 1)) begin
                    sum_d   = res_d;
                    cout_d  = c[4];
                    // carry into the MSB vs carry out of it
                    ovf_d   = c[3] ^ c[4];
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder at WIDTH=4, 16 and 32 with per-width scoreboards.
module tb_nibble_serial_adder;
    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ov;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        st4 = 0, ci4 = 0, busy4, done4, co4, ov4;
    logic [3:0]  a4 = '0, b4 = '0, sum4;
    logic        st16 = 0, ci16 = 0, busy16, done16, co16, ov16;
    logic [15:0] a16 = '0, b16 = '0, sum16;
    logic        st32 = 0, ci32 = 0, busy32, done32, co32, ov32;
    logic [31:0] a32 = '0, b32 = '0, sum32;

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4), .cin(ci4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(co4), .ovf(ov4));
    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(st16), .a(a16), .b(b16), .cin(ci16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(co16), .ovf(ov16));
    nibble_serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(st32), .a(a32), .b(b32), .cin(ci32),
        .busy(busy32), .done(done32), .sum(sum32), .cout(co32), .ovf(ov32));

    exp_t q4[$], q16[$], q32[$];
    int acc4 = 0, acc16 = 0, acc32 = 0;
    int dn4 = 0, dn16 = 0, dn32 = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain wide addition, overflow from operand/result sign bits
    function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                   input logic ci);
        exp_t        e;
        logic [31:0] m;
        logic [32:0] t;
        m    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        av   = av & m;
        bv   = bv & m;
        t    = {1'b0, av} + {1'b0, bv} + {32'd0, ci};
        e.s  = t[31:0] & m;
        e.co = t[w];
        e.ov = (av[w-1] == bv[w-1]) && (e.s[w-1] != av[w-1]);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done4) begin
            dn4++;
            if (q4.size() == 0) chk("d4_unexpected", 1, 0);
            else begin
                e = q4.pop_front();
                chk("sum4", 32'(sum4), e.s); chk("cout4", 32'(co4), 32'(e.co));
                chk("ovf4", 32'(ov4), 32'(e.ov));
            end
        end
        if (rst_n && done16) begin
            dn16++;
            if (q16.size() == 0) chk("d16_unexpected", 1, 0);
            else begin
                e = q16.pop_front();
                chk("sum16", 32'(sum16), e.s); chk("cout16", 32'(co16), 32'(e.co));
                chk("ovf16", 32'(ov16), 32'(e.ov));
            end
        end
        if (rst_n && done32) begin
            dn32++;
            if (q32.size() == 0) chk("d32_unexpected", 1, 0);
            else begin
                e = q32.pop_front();
                chk("sum32", sum32, e.s); chk("cout32", 32'(co32), 32'(e.co));
                chk("ovf32", 32'(ov32), 32'(e.ov));
            end
        end
    end

    task automatic wait_done16(input string nm);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done16) return;
        end
        chk(nm, 0, 1);
    endtask

    // Pulse start for one cycle with an expected result queued, then wait for done.
    task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                        input exp_t e);
        @(negedge clk);
        st16 = 1; a16 = av; b16 = bv; ci16 = ci;
        q16.push_back(e); acc16++;
        @(negedge clk);
        st16 = 0; a16 = $urandom; b16 = $urandom; ci16 = 1'($urandom);
        wait_done16("op16_timeout");
    endtask

    vec_t vt[8];
    int   t0;
    exp_t e;

    initial begin
        vt[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[2] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
        vt[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[5] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[6] = '{16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[7] = '{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 1'b1, 1'b0};

        #2 rst_n = 0;
        #1;
        chk("rst_busy16", 32'(busy16), 0); chk("rst_done16", 32'(done16), 0);
        chk("rst_sum16", 32'(sum16), 0);   chk("rst_cout16", 32'(co16), 0);
        chk("rst_ovf16", 32'(ov16), 0);    chk("rst_sum32", sum32, 0);
        chk("rst_busy4", 32'(busy4), 0);
        #10 rst_n = 1;

        // Latency: busy for NIBBLES cycles, done in the following cycle, sum held meanwhile
        @(negedge clk);
        st16 = 1; a16 = 16'h1234; b16 = 16'h4321; ci16 = 0;
        q16.push_back('{32'h5555, 1'b0, 1'b0}); acc16++;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            st16 = 0;
            chk($sformatf("lat_busy_c%0d", k), 32'(busy16), 1);
            chk($sformatf("lat_done_c%0d", k), 32'(done16), 0);
            chk($sformatf("lat_hold_c%0d", k), 32'(sum16), 0);
        end
        @(negedge clk);
        chk("lat_done", 32'(done16), 1);
        chk("lat_busy_off", 32'(busy16), 0);
        @(negedge clk);
        chk("lat_done_pulse", 32'(done16), 0);

        for (int i = 0; i < 8; i++)
            op16(vt[i].a, vt[i].b, vt[i].ci, '{32'(vt[i].s), vt[i].co, vt[i].ov});

        // start held through RUN with changing operands must not re-capture
        @(negedge clk);
        st16 = 1; a16 = 16'h0001; b16 = 16'h0001; ci16 = 0;
        q16.push_back('{32'h0002, 1'b0, 1'b0}); acc16++;
        @(negedge clk);
        a16 = 16'hAAAA;
        repeat (2) @(negedge clk);
        st16 = 0;
        wait_done16("hold_timeout");

        // Back-to-back: start in the DONE cycle, second done 5 cycles later
        op16(16'h1111, 16'h2222, 1'b0, '{32'h3333, 1'b0, 1'b0});
        t0 = cyc;
        st16 = 1; a16 = 16'h0F0F; b16 = 16'h0101; ci16 = 0;
        q16.push_back('{32'h1010, 1'b0, 1'b0}); acc16++;
        @(negedge clk);
        st16 = 0;
        wait_done16("b2b_timeout");
        chk("b2b_spacing", 32'(cyc - t0), 5);

        // Asynchronous reset mid-RUN at counter=2
        @(negedge clk);
        st16 = 1; a16 = 16'h1234; b16 = 16'h1111; ci16 = 0;
        q16.push_back('{32'h2345, 1'b0, 1'b0}); acc16++;
        repeat (3) @(negedge clk);
        st16 = 0;
        #2 rst_n = 0;
        #1;
        chk("amr_busy", 32'(busy16), 0); chk("amr_done", 32'(done16), 0);
        chk("amr_sum", 32'(sum16), 0);   chk("amr_cout", 32'(co16), 0);
        chk("amr_ovf", 32'(ov16), 0);
        acc16 -= q16.size();
        q16.delete();
        #4 rst_n = 1;
        t0 = dn16;
        repeat (6) @(negedge clk);
        chk("amr_no_done", 32'(dn16 - t0), 0);
        op16(16'h00FF, 16'h0001, 1'b0, '{32'h0100, 1'b0, 1'b0});

        fork
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                st4 = 1; a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom);
                q4.push_back(model(4, 32'(a4), 32'(b4), ci4)); acc4++;
                @(negedge clk);
                st4 = 0;
                for (int k = 0; k < 20 && !done4; k++) @(negedge clk);
                if (!done4) chk("r4_timeout", 0, 1);
            end
            for (int i = 0; i < 1000; i++) begin
                logic [15:0] ra, rb;
                logic        rc;
                ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
                if (i % 8 == 0) rb = ~ra;
                op16(ra, rb, rc, model(16, 32'(ra), 32'(rb), rc));
            end
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                st32 = 1; a32 = $urandom; b32 = $urandom; ci32 = 1'($urandom);
                if (i % 8 == 0) b32 = ~a32;
                q32.push_back(model(32, a32, b32, ci32)); acc32++;
                @(negedge clk);
                st32 = 0;
                for (int k = 0; k < 20 && !done32; k++) @(negedge clk);
                if (!done32) chk("r32_timeout", 0, 1);
            end
        join

        repeat (3) @(negedge clk);
        chk("cnt4", 32'(dn4), 32'(acc4));
        chk("cnt16", 32'(dn16), 32'(acc16));
        chk("cnt32", 32'(dn32), 32'(acc32));
        chk("q_left", 32'(q4.size() + q16.size() + q32.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
